// File: rtl/hs32_sram_arbiter.sv
// -----------------------------------------------------------------------------
// hs32_sram_arbiter
//
// Shares the read/write port (port 0) of one sram_1rw1r_32_256_8_sky130 macro
// between the management Wishbone slave and the hs32 core buffer interface.
// Contention is resolved round-robin, and only one access is in flight at a
// time. Every SRAM control is driven straight from a flop.
//
// Each access walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   ISSUE  chip select is low for exactly one cycle.
//   WAIT   the macro drives dout0.
//   RESP   the owner receives a one-cycle ack, and read data sits on its dat_o.
//
// Ports
//   wb_clk_i, wb_rst_i   single clock (also clocks SRAM clk0), async active-high reset
//   wbs_*                Wishbone slave. A hit needs adr[31:AW+2] == WB_BASE[31:AW+2].
//                        The word index is adr[AW+1:2].
//   cpu_*                hs32 core request/ack interface. Word addressed.
//   sram_*               port 0 of the SRAM macro (csb0/web0 are active low)
// -----------------------------------------------------------------------------
module hs32_sram_arbiter #(
   parameter int          AW      = 8,
   parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [3:0]    cpu_sel_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [31:0]   cpu_dat_i,
   output logic          cpu_ack_o,
   output logic [31:0]   cpu_dat_o,
   output logic          sram_csb0,
   output logic          sram_web0,
   output logic [3:0]    sram_wmask0,
   output logic [AW-1:0] sram_addr0,
   output logic [31:0]   sram_din0,
   input  logic [31:0]   sram_dout0
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic            owner_cpu;
   logic            last_cpu;
   logic            lat_we;

   logic            wb_hit;
   logic            wb_req;
   logic            cpu_req;
   logic            grant_cpu;
   logic            req_we;
   logic [3:0]      req_sel;
   logic [AW-1:0]   req_addr;
   logic [31:0]     req_dat;
   logic            unused_adr_bits;

   // The byte-offset bits of the Wishbone address play no part in word
   // addressing. They are reduced here only so that they count as consumed.
   assign unused_adr_bits = ^wbs_adr_i[1:0];

   // Request decode and round-robin choice.
   // Only the upper address bits take part in the window decode. A Wishbone
   // cycle outside the window is never seen as a request, so it is never acked.
   // When both sides ask, the side that did not win last time gets the port.
   always_comb begin
      wb_hit    = (wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);
      wb_req    = wbs_cyc_i & wbs_stb_i & wb_hit;
      cpu_req   = cpu_req_i;
      grant_cpu = cpu_req & (~wb_req | ~last_cpu);
      req_we    = grant_cpu ? cpu_we_i   : wbs_we_i;
      req_sel   = grant_cpu ? cpu_sel_i  : wbs_sel_i;
      req_addr  = grant_cpu ? cpu_addr_i : wbs_adr_i[AW+1:2];
      req_dat   = grant_cpu ? cpu_dat_i  : wbs_dat_i;
   end

   // Sequencer and registered SRAM controls.
   // The granted request is loaded straight into the SRAM address and data
   // flops on the granting edge. Those flops then hold until the next grant,
   // so they double as the latched copy of the request.
   // din0 is only reloaded for writes. Between accesses, addr0 and din0 keep
   // their last values.
   // Read data is captured on the WAIT->RESP edge into the owner's dat_o
   // only. The other requester's data output is never touched.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         owner_cpu   <= 1'b0;
         last_cpu    <= 1'b1;
         lat_we      <= 1'b0;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         wbs_dat_o   <= '0;
         cpu_dat_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wb_req || cpu_req) begin
                  owner_cpu   <= grant_cpu;
                  last_cpu    <= grant_cpu;
                  lat_we      <= req_we;
                  sram_csb0   <= 1'b0;
                  sram_web0   <= ~req_we;
                  sram_wmask0 <= req_we ? req_sel : 4'b0000;
                  sram_addr0  <= req_addr;
                  if (req_we) begin
                     sram_din0 <= req_dat;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               sram_csb0   <= 1'b1;
               sram_web0   <= 1'b1;
               sram_wmask0 <= 4'b0000;
               state       <= WAIT;
            end
            WAIT: begin
               if (!lat_we) begin
                  if (owner_cpu) begin
                     cpu_dat_o <= sram_dout0;
                  end else begin
                     wbs_dat_o <= sram_dout0;
                  end
               end
               state <= RESP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Acks are decoded from the registered state.
   // The Wishbone ack is also gated by the live cyc/stb. A master that
   // abandons its cycle mid-access therefore gets no ack, even though the
   // SRAM access itself still runs to completion.
   always_comb begin
      wbs_ack_o = (state == RESP) & ~owner_cpu & wbs_cyc_i & wbs_stb_i;
      cpu_ack_o = (state == RESP) & owner_cpu;
   end

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hs32_sram_arbiter
//
// Directed bench for hs32_sram_arbiter.
// A behavioural model of the SRAM macro port sits behind the arbiter.
// Single transactions come from a table of hand-computed records.
// The multi-cycle corner cases are written out as explicit sequences:
// reset abort, contention, Wishbone abort and decode miss.
// -----------------------------------------------------------------------------
module tb_hs32_sram_arbiter;

   typedef struct {
      bit          is_cpu;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        cpu_req_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [7:0]  cpu_addr_i;
   logic [31:0] cpu_dat_i;
   logic        cpu_ack_o;
   logic [31:0] cpu_dat_o;
   logic        sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_wmask0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0;

   logic [31:0] mem [0:255];
   int          n_checks;
   int          n_fails;
   vec_t        vecs [12];

   hs32_sram_arbiter dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_sel_i   (cpu_sel_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_dat_i   (cpu_dat_i),
      .cpu_ack_o   (cpu_ack_o),
      .cpu_dat_o   (cpu_dat_o),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   // Free-running clock, 10 time units per period.
   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // Behavioural model of SRAM port 0.
   // Controls are sampled on the rising edge. Masked bytes are written, and
   // read data appears after that same edge.
   always @(posedge wb_clk_i) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wmask0[b]) begin
                  mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
               end
            end
         end else begin
            sram_dout0 <= mem[sram_addr0];
         end
      end
   end

   // Single comparison. Prints one FAIL line on a miscompare.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one transaction on one port, starting with the arbiter idle.
   // Along the way it checks:
   //   - the SRAM controls during ISSUE;
   //   - ack latency;
   //   - read data;
   //   - that the other port's outputs are left alone.
   task automatic applyStimulus(input string tag, input vec_t v);
      int          cnt;
      bit          got;
      logic [31:0] own_before;
      logic [31:0] other_before;
      logic [7:0]  exp_addr;
      @(negedge wb_clk_i);
      own_before   = v.is_cpu ? cpu_dat_o : wbs_dat_o;
      other_before = v.is_cpu ? wbs_dat_o : cpu_dat_o;
      exp_addr     = v.is_cpu ? v.addr[7:0] : v.addr[9:2];
      if (v.is_cpu) begin
         cpu_req_i  = 1'b1;
         cpu_we_i   = v.we;
         cpu_sel_i  = v.sel;
         cpu_addr_i = v.addr[7:0];
         cpu_dat_i  = v.data;
      end else begin
         wbs_cyc_i = 1'b1;
         wbs_stb_i = 1'b1;
         wbs_we_i  = v.we;
         wbs_sel_i = v.sel;
         wbs_adr_i = v.addr;
         wbs_dat_i = v.data;
      end
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 10) begin
         @(negedge wb_clk_i);
         cnt++;
         if (cnt == 1) begin
            checkOutput({tag, "_csb0"}, {31'b0, sram_csb0}, 32'h0);
            checkOutput({tag, "_web0"}, {31'b0, sram_web0}, {31'b0, ~v.we});
            checkOutput({tag, "_addr0"}, {24'b0, sram_addr0}, {24'b0, exp_addr});
            checkOutput({tag, "_wmask0"}, {28'b0, sram_wmask0}, v.we ? {28'b0, v.sel} : 32'h0);
            if (v.we) begin
               checkOutput({tag, "_din0"}, sram_din0, v.data);
            end
         end
         if (v.is_cpu ? cpu_ack_o : wbs_ack_o) begin
            got = 1'b1;
         end
      end
      checkOutput({tag, "_ack_seen"}, {31'b0, got}, 32'h1);
      if (got) begin
         checkOutput({tag, "_latency"}, cnt, 32'd3);
         checkOutput({tag, "_other_ack"}, {31'b0, v.is_cpu ? wbs_ack_o : cpu_ack_o}, 32'h0);
         checkOutput({tag, "_other_dat"}, v.is_cpu ? wbs_dat_o : cpu_dat_o, other_before);
         if (v.we) begin
            checkOutput({tag, "_dat_hold"}, v.is_cpu ? cpu_dat_o : wbs_dat_o, own_before);
         end else begin
            checkOutput({tag, "_rdata"}, v.is_cpu ? cpu_dat_o : wbs_dat_o, v.exp);
         end
      end
      @(posedge wb_clk_i);
      #1;
      if (v.is_cpu) begin
         cpu_req_i = 1'b0;
      end else begin
         wbs_cyc_i = 1'b0;
         wbs_stb_i = 1'b0;
      end
   endtask

   // Main sequence: reset checks, reset abort, table, then corner cases.
   initial begin
      int          bad;
      int          acks;
      int          n;
      logic [31:0] exp_d;
      vec_t        rv;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      n_checks   = 0;
      n_fails    = 0;
      wb_rst_i   = 1'b1;
      wbs_cyc_i  = 1'b0;
      wbs_stb_i  = 1'b0;
      wbs_we_i   = 1'b0;
      wbs_sel_i  = 4'h0;
      wbs_adr_i  = 32'h0;
      wbs_dat_i  = 32'h0;
      cpu_req_i  = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_sel_i  = 4'h0;
      cpu_addr_i = 8'h0;
      cpu_dat_i  = 32'h0;

      vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 4'h5, 32'h0000_0004, 32'h1122_3344, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'hFF22_FF44};
      vecs[6]  = '{1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'hFF22_FF44};
      vecs[7]  = '{1'b0, 1'b1, 4'hF, 32'h3000_03FC, 32'hA5A5_0F0F, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 4'hF, 32'h0000_00FF, 32'h0, 32'hA5A5_0F0F};
      vecs[9]  = '{1'b0, 1'b1, 4'h1, 32'h3000_0000, 32'hAABB_CCDD, 32'h0};
      vecs[10] = '{1'b1, 1'b1, 4'h8, 32'h0000_0000, 32'h7766_5544, 32'h0};
      vecs[11] = '{1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'h7700_00DD};

      // Values held while reset is asserted.
      repeat (2) @(negedge wb_clk_i);
      checkOutput("rst_csb0", {31'b0, sram_csb0}, 32'h1);
      checkOutput("rst_web0", {31'b0, sram_web0}, 32'h1);
      checkOutput("rst_wmask0", {28'b0, sram_wmask0}, 32'h0);
      checkOutput("rst_addr0", {24'b0, sram_addr0}, 32'h0);
      checkOutput("rst_din0", sram_din0, 32'h0);
      checkOutput("rst_acks", {30'b0, wbs_ack_o, cpu_ack_o}, 32'h0);
      checkOutput("rst_wbs_dat", wbs_dat_o, 32'h0);
      checkOutput("rst_cpu_dat", cpu_dat_o, 32'h0);
      wb_rst_i = 1'b0;

      // Reset arrives while a write is in ISSUE: the access is abandoned at
      // once and never acked.
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3000_0024;
      wbs_dat_i = 32'h1234_5678;
      @(negedge wb_clk_i);
      checkOutput("t1_issue_csb0", {31'b0, sram_csb0}, 32'h0);
      wb_rst_i = 1'b1;
      #1;
      checkOutput("t1_async_csb0", {31'b0, sram_csb0}, 32'h1);
      checkOutput("t1_async_web0", {31'b0, sram_web0}, 32'h1);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      bad = 0;
      repeat (2) begin
         @(negedge wb_clk_i);
         bad += int'(wbs_ack_o) + int'(cpu_ack_o);
      end
      wb_rst_i = 1'b0;
      repeat (4) begin
         @(negedge wb_clk_i);
         bad += int'(wbs_ack_o) + int'(cpu_ack_o);
      end
      checkOutput("t1_no_ack", bad, 32'h0);
      rv = '{1'b0, 1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'h0};
      applyStimulus("t1_readback", rv);

      // Table of single transactions.
      for (int i = 0; i < 12; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i]);
      end

      // Both sides request continuously, starting from reset. Grants must
      // alternate WB, CPU, WB, ... with one ack every four cycles.
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      wbs_cyc_i  = 1'b1;
      wbs_stb_i  = 1'b1;
      wbs_we_i   = 1'b0;
      wbs_adr_i  = 32'h3000_0010;
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 8'hFF;
      acks = 0;
      n    = 0;
      while (acks < 6 && n < 40) begin
         @(negedge wb_clk_i);
         n++;
         if (wbs_ack_o || cpu_ack_o) begin
            checkOutput($sformatf("t4_ack%0d_cycle", acks), n, 3 + 4 * acks);
            checkOutput($sformatf("t4_ack%0d_owner", acks), {31'b0, cpu_ack_o}, acks % 2);
            checkOutput($sformatf("t4_ack%0d_both", acks), {31'b0, wbs_ack_o & cpu_ack_o}, 32'h0);
            exp_d = (acks % 2 == 1) ? 32'hA5A5_0F0F : 32'hFF22_FF44;
            checkOutput($sformatf("t4_ack%0d_data", acks), cpu_ack_o ? cpu_dat_o : wbs_dat_o, exp_d);
            acks++;
         end
      end
      checkOutput("t4_ack_count", acks, 32'd6);
      @(posedge wb_clk_i);
      #1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      cpu_req_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);

      // Wishbone read abandoned during WAIT: the SRAM read still happens,
      // no ack is given, and the core is served normally afterwards.
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 32'h3000_0000;
      @(negedge wb_clk_i);
      checkOutput("t5_read_csb0", {31'b0, sram_csb0}, 32'h0);
      checkOutput("t5_read_web0", {31'b0, sram_web0}, 32'h1);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge wb_clk_i);
         bad += int'(wbs_ack_o);
      end
      checkOutput("t5_no_wb_ack", bad, 32'h0);
      rv = '{1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h7700_00DD};
      applyStimulus("t5_cpu", rv);

      // Strobes outside the decode window never touch the SRAM and are never
      // acked. The core is still served while one of them is held.
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_sel_i = 4'hF;
      wbs_dat_i = 32'hBAD0_BAD0;
      wbs_adr_i = 32'h2000_0000;
      bad = 0;
      repeat (6) begin
         @(negedge wb_clk_i);
         bad += int'(!sram_csb0) + int'(wbs_ack_o) + int'(cpu_ack_o);
      end
      checkOutput("t6_miss_low", bad, 32'h0);
      wbs_adr_i = 32'h3000_0400;
      bad = 0;
      repeat (6) begin
         @(negedge wb_clk_i);
         bad += int'(!sram_csb0) + int'(wbs_ack_o) + int'(cpu_ack_o);
      end
      checkOutput("t6_miss_high", bad, 32'h0);
      rv = '{1'b1, 1'b0, 4'hF, 32'h0000_00FF, 32'h0, 32'hA5A5_0F0F};
      applyStimulus("t6_cpu", rv);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
      $finish;
   end

endmodule
